// File: rtl/note_highway_if.sv
// Chart ROM read bus between note_highway (master) and the synchronous chart ROM (slave).
//   chart_addr : ROM read address, driven by the master
//   chart_q    : ROM data, valid one cycle after chart_addr; [3:0] lane notes, [4] end-of-chart marker
interface note_highway_if #(
    parameter int unsigned CHART_AW = 10
);
    logic [CHART_AW-1:0] chart_addr;
    logic [4:0]          chart_q;

    modport master (output chart_addr, input  chart_q);
    modport slave  (input  chart_addr, output chart_q);
endinterface

// File: rtl/note_highway.sv
// Guitar Hero gameplay front end: reads a note chart from a synchronous ROM,
// scrolls it down a four-lane highway once per game tick, and debounces strum.
//   clock, reset  : master clock, synchronous active-high reset
//   enable        : run/play; low pauses the highway
//   chart         : ROM read bus (master modport)
//   strum_raw     : asynchronous strum switch
//   gameclk       : tick square wave, 50% duty
//   intersections : highway row 0 (hit zone)
//   strum         : debounced strum level
//   highway       : all rows, row i at [4i+3:4i]
//   done          : chart fully drained
// TICK_DIV must be even and >= 4; DEPTH >= 2; DEBOUNCE >= 2.
module note_highway #(
    parameter int unsigned TICK_DIV = 833333,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned CHART_AW = 10,
    parameter int unsigned DEBOUNCE = 65536
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    note_highway_if.master       chart,
    input  logic                 strum_raw,
    output logic                 gameclk,
    output logic [3:0]           intersections,
    output logic                 strum,
    output logic [4*DEPTH-1:0]   highway,
    output logic                 done
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam int unsigned DR_W  = $clog2(DEPTH + 1);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2);
    localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(DEPTH - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_PLAY  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DR_W-1:0]      drain_cnt_q;
    logic [CHART_AW-1:0]  addr_q;
    logic [3:0]           next_row_q;
    logic [4*DEPTH-1:0]   highway_q;
    logic                 gameclk_q;
    logic                 done_q;

    logic                 sync1_q;
    logic                 sync2_q;
    logic [DB_W-1:0]      db_cnt_q;
    logic                 strum_q;

    logic                 running;
    logic                 tick;
    logic [CNT_W-1:0]     cnt_d;

    // Tick counter advances only while scrolling and enabled; a tick is the wrap edge.
    always_comb begin
        running = ((state_q == S_PLAY) || (state_q == S_DRAIN)) && enable;
        tick    = running && (cnt_q == CNT_LAST);
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    // Highway FSM, tick counter, chart fetch and scroll.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            drain_cnt_q <= '0;
            addr_q      <= '0;
            next_row_q  <= '0;
            highway_q   <= '0;
            gameclk_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // gameclk tracks the count it is registered alongside, so it is glitch-free
            if (running) begin
                cnt_q     <= cnt_d;
                gameclk_q <= (cnt_d >= CNT_HALF);
            end

            case (state_q)
                S_IDLE: begin
                    addr_q    <= '0;
                    highway_q <= '0;
                    cnt_q     <= '0;
                    gameclk_q <= 1'b0;
                    if (enable) begin
                        state_q <= S_PRIME;
                    end
                end

                // ROM row 0 has been on chart_q since IDLE held the address at 0.
                S_PRIME: begin
                    next_row_q  <= chart.chart_q[3:0];
                    addr_q      <= CHART_AW'(1);
                    drain_cnt_q <= '0;
                    state_q     <= chart.chart_q[4] ? S_DRAIN : S_PLAY;
                end

                // next_row_q always holds the row fetched on the previous tick; a
                // marker row is captured but never shifted in because DRAIN feeds zeros.
                S_PLAY: begin
                    if (tick) begin
                        highway_q  <= {next_row_q, highway_q[4*DEPTH-1:4]};
                        next_row_q <= chart.chart_q[3:0];
                        addr_q     <= addr_q + CHART_AW'(1);
                        if (chart.chart_q[4] || (&addr_q)) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (tick) begin
                        highway_q   <= {4'b0000, highway_q[4*DEPTH-1:4]};
                        drain_cnt_q <= drain_cnt_q + DR_W'(1);
                        if (drain_cnt_q == DR_LAST) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    done_q <= 1'b1;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Strum: 2-flop synchronizer, then a stability counter that must saturate before the level flips.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_cnt_q <= '0;
            strum_q  <= 1'b0;
        end else begin
            sync1_q <= strum_raw;
            sync2_q <= sync1_q;
            if (sync2_q == strum_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                strum_q  <= sync2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    assign chart.chart_addr = addr_q;
    assign gameclk          = gameclk_q;
    assign intersections    = highway_q[3:0];
    assign highway          = highway_q;
    assign done             = done_q;
    assign strum            = strum_q;

endmodule

// File: tb/tb_note_highway.sv
// Self-checking bench for note_highway: strum debounce vector table, the
// reference chart scenarios (plain, pause, marker at row 0, reset mid-play),
// and randomized charts with random enable gaps checked against a tick-level model.
module tb_note_highway;

    localparam int TD = 4;
    localparam int DP = 4;
    localparam int AW = 4;
    localparam int DB = 8;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              strum_raw;
    logic              gameclk;
    logic [3:0]        intersections;
    logic              strum;
    logic [4*DP-1:0]   highway;
    logic              done;

    logic [4:0]        rom [0:(1<<AW)-1];

    int n_chk  = 0;
    int n_fail = 0;

    note_highway_if #(.CHART_AW(AW)) chart_bus ();

    note_highway #(
        .TICK_DIV (TD),
        .DEPTH    (DP),
        .CHART_AW (AW),
        .DEBOUNCE (DB)
    ) dut (
        .clock         (clk),
        .reset         (reset),
        .enable        (enable),
        .chart         (chart_bus),
        .strum_raw     (strum_raw),
        .gameclk       (gameclk),
        .intersections (intersections),
        .strum         (strum),
        .highway       (highway),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM, one cycle latency.
    always @(posedge clk) chart_bus.chart_q <= rom[chart_bus.chart_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Lanes of chart row idx if it is a real note row, else empty.
    function automatic logic [3:0] exp_row(input int idx, input int e);
        if (idx >= 0 && idx < e) return rom[idx[AW-1:0]][3:0];
        return 4'h0;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " addr"},    64'(chart_bus.chart_addr), 64'd0);
        check({tag, " gameclk"}, 64'(gameclk),              64'd0);
        check({tag, " inter"},   64'(intersections),        64'd0);
        check({tag, " highway"}, 64'(highway),              64'd0);
        check({tag, " done"},    64'(done),                 64'd0);
        check({tag, " strum"},   64'(strum),                64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < (1 << AW); i++) rom[i] = 5'h00;
    endtask

    // Plays a chart with the end marker at row e from IDLE to DONE. The model counts
    // enabled cycles after PLAY/DRAIN entry: every TD of them is one tick, and the
    // whole run is e + DP ticks. After tick tk, highway row i holds chart row tk+i-DP.
    task automatic run_chart(input int e, input bit rnd, input int p_at, input int p_len, input string tag);
        int a;
        int tk;
        int cnt;
        int tend;
        int c;
        int extra;
        logic [4*DP-1:0] hw;
        tend  = e + DP;
        a     = 0;
        tk    = 0;
        extra = 0;

        @(negedge clk);
        enable = 1'b1;
        @(posedge clk); #1;
        check({tag, " prime addr"},    64'(chart_bus.chart_addr), 64'd0);
        check({tag, " prime highway"}, 64'(highway),              64'd0);
        @(posedge clk); #1;
        check({tag, " entry addr"},    64'(chart_bus.chart_addr), 64'd1);
        check({tag, " entry gameclk"}, 64'(gameclk),              64'd0);

        c = 0;
        while (c < 2000 && extra < 4) begin
            @(negedge clk);
            enable = !((c >= p_at && c < p_at + p_len) || (rnd && $urandom_range(0, 3) == 0));
            @(posedge clk); #1;
            if (enable && a < tend * TD) a++;
            tk  = a / TD;
            cnt = (tk >= tend) ? 0 : a % TD;
            for (int i = 0; i < DP; i++) hw[4*i +: 4] = exp_row(tk + i - DP, e);
            check({tag, " gameclk"}, 64'(gameclk),              64'(cnt >= TD / 2));
            check({tag, " inter"},   64'(intersections),        64'(hw[3:0]));
            check({tag, " highway"}, 64'(highway),              64'(hw));
            check({tag, " addr"},    64'(chart_bus.chart_addr), 64'(1 + ((tk < e) ? tk : e)));
            check({tag, " done"},    64'(done),                 64'(tk == tend));
            if (tk == tend) extra++;
            c++;
        end
        check({tag, " done at end"}, 64'(done), 64'd1);
        @(negedge clk);
        enable = 1'b0;
    endtask

    typedef struct {
        logic raw;
        int   hold;
        logic exp;
    } strum_vec_t;

    strum_vec_t svec [12];

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        strum_raw = 1'b0;
        clear_rom();

        // raw level, cycles held, expected strum after that many cycles
        svec[0]  = '{1'b1,  5, 1'b0};
        svec[1]  = '{1'b0, 12, 1'b0};
        svec[2]  = '{1'b1,  5, 1'b0};
        svec[3]  = '{1'b0, 12, 1'b0};
        svec[4]  = '{1'b1,  9, 1'b0};
        svec[5]  = '{1'b1,  1, 1'b1};
        svec[6]  = '{1'b0,  9, 1'b1};
        svec[7]  = '{1'b0,  1, 1'b0};
        svec[8]  = '{1'b1, 10, 1'b1};
        svec[9]  = '{1'b0,  3, 1'b1};
        svec[10] = '{1'b1, 10, 1'b1};
        svec[11] = '{1'b0, 10, 1'b0};

        do_reset();

        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            strum_raw = svec[k].raw;
            repeat (svec[k].hold) @(posedge clk);
            #1;
            check($sformatf("strum vec%0d", k), 64'(strum), 64'(svec[k].exp));
        end
        @(negedge clk);
        strum_raw = 1'b0;
        repeat (DB + 4) @(posedge clk);

        // Reference chart: 0001, 0010, 0000, 1000, end (marker lanes must be discarded).
        clear_rom();
        rom[0] = 5'h01;
        rom[1] = 5'h02;
        rom[2] = 5'h00;
        rom[3] = 5'h08;
        rom[4] = 5'h1F;
        do_reset();
        run_chart(4, 1'b0, 1000, 0, "plan");

        // Same chart with a 10-cycle enable gap mid-PLAY.
        do_reset();
        run_chart(4, 1'b0, 9, 10, "pause");

        // Reset for one cycle mid-PLAY, then replay from row 0.
        do_reset();
        @(negedge clk);
        enable = 1'b1;
        repeat (2 + TD * 5 + 2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midreset idle addr",    64'(chart_bus.chart_addr), 64'd0);
        check("midreset idle highway", 64'(highway),              64'd0);
        run_chart(4, 1'b0, 1000, 0, "replay");

        // End marker at row 0: straight to DRAIN, nothing ever reaches the hit zone.
        clear_rom();
        rom[0] = 5'h1A;
        rom[1] = 5'h0F;
        do_reset();
        run_chart(0, 1'b0, 1000, 0, "end0");

        // Random charts, half with random enable gaps.
        for (int r = 0; r < 8; r++) begin
            int e;
            e = $urandom_range(0, 12);
            for (int i = 0; i < (1 << AW); i++) rom[i] = {1'b0, 4'($urandom)};
            rom[e] = {1'b1, 4'($urandom)};
            do_reset();
            run_chart(e, r[0], 1000, 0, $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
